// File: rtl/flappy_draw_engine.sv
// Rectangle sweep engine: paints the bird sprite or one wall column (with its
// fly-through gap) pixel by pixel into the VGA adapter, then pulses done.
module flappy_draw_engine #(
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter int          BIRD_W      = 4,
    parameter int          BIRD_H      = 4,
    parameter int          WALL_W      = 8,
    parameter int          GAP_H       = 30,
    parameter logic [2:0]  BIRD_COLOUR = 3'b110,
    parameter logic [2:0]  WALL_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic       sel,
    input  logic       erase,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [6:0] gap_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    localparam int CXW = $clog2(WALL_W + 1);
    localparam int CYW = $clog2(SCREEN_H + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    state_t         state, state_nx;
    logic           l_sel, l_erase;
    logic [7:0]     l_x;
    logic [6:0]     l_y, l_gap, base;
    logic [CXW-1:0] w, cx;
    logic [CYW-1:0] h, cy;

    logic [8:0]     px;
    logic [7:0]     py, gap_hi;
    logic           in_gap, vis, last;
    logic [2:0]     pix_col;

    always_comb begin
        px      = {1'b0, l_x} + 9'(cx);
        py      = {1'b0, base} + 8'(cy);
        gap_hi  = {1'b0, l_gap} + 8'(GAP_H);
        in_gap  = !l_sel && (py >= {1'b0, l_gap}) && (py < gap_hi);
        vis     = (px < 9'(SCREEN_W)) && (py < 8'(SCREEN_H)) && !in_gap;
        last    = (cx == w - 1'b1) && (cy == h - 1'b1);
        pix_col = l_erase ? BG_COLOUR : (l_sel ? BIRD_COLOUR : WALL_COLOUR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = LOAD;
            LOAD:    state_nx = DRAW;
            DRAW:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // busy and done are registered so that busy spans the done cycle and a
    // held req is re-accepted on the edge that closes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            l_sel   <= 1'b0;
            l_erase <= 1'b0;
            l_x     <= '0;
            l_y     <= '0;
            l_gap   <= '0;
            base    <= '0;
            w       <= '0;
            h       <= '0;
            cx      <= '0;
            cy      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            plot    <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= req;
                    if (req) begin
                        l_sel   <= sel;
                        l_erase <= erase;
                        l_x     <= obj_x;
                        l_y     <= obj_y;
                        l_gap   <= gap_y;
                        cx      <= '0;
                        cy      <= '0;
                    end
                end
                LOAD: begin
                    if (l_sel) begin
                        w    <= CXW'(BIRD_W);
                        h    <= CYW'(BIRD_H);
                        base <= l_y;
                    end else begin
                        w    <= CXW'(WALL_W);
                        h    <= CYW'(SCREEN_H);
                        base <= '0;
                    end
                end
                DRAW: begin
                    plot <= vis;
                    if (vis) begin
                        x      <= px[7:0];
                        y      <= py[6:0];
                        colour <= pix_col;
                    end
                    if (cx == w - 1'b1) begin
                        cx <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                DONE: begin
                    plot <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flappy_draw_engine.sv
// Scoreboard bench for flappy_draw_engine: stimulus pushes the expected pixel
// stream, done edge and busy window; a negedge monitor pops and compares.
module tb_flappy_draw_engine;

    logic       clk = 1'b0, resetn = 1'b0, req = 1'b0, sel = 1'b0, erase = 1'b0;
    logic [7:0] obj_x = '0;
    logic [6:0] obj_y = '0, gap_y = '0;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    flappy_draw_engine dut (
        .clk(clk), .resetn(resetn), .req(req), .sel(sel), .erase(erase),
        .obj_x(obj_x), .obj_y(obj_y), .gap_y(gap_y),
        .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] c;
        int         cyc;
    } pix_t;

    pix_t pq[$];
    int   dq[$];
    int   wlo[$], whi[$];
    int   n_cmp = 0, n_bad = 0;
    bit   in_reset = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: enumerate the rectangle row by row and keep visible pixels.
    task automatic model(input bit s, input bit e, input int ox, input int oy,
                         input int gy, input int e0);
        int wd, ht, base, idx, px, py;
        bit vis;
        pix_t p;
        wd   = s ? 4 : 8;
        ht   = s ? 4 : 120;
        base = s ? oy : 0;
        idx  = 0;
        for (int r = 0; r < ht; r++) begin
            for (int c = 0; c < wd; c++) begin
                px  = ox + c;
                py  = base + r;
                vis = (px < 160) && (py < 120) && !(!s && py >= gy && py < gy + 30);
                if (vis) begin
                    p.px  = px[7:0];
                    p.py  = py[6:0];
                    p.c   = e ? 3'b000 : (s ? 3'b110 : 3'b010);
                    p.cyc = e0 + 2 + idx;
                    pq.push_back(p);
                end
                idx++;
            end
        end
        dq.push_back(e0 + wd * ht + 2);
        wlo.push_back(e0);
        whi.push_back(e0 + wd * ht + 2);
    endtask

    task automatic drive(input bit s, input bit e, input int ox, input int oy, input int gy);
        sel   = s;
        erase = e;
        obj_x = ox[7:0];
        obj_y = oy[6:0];
        gap_y = gy[6:0];
    endtask

    task automatic scramble();
        sel   = 1'($urandom);
        erase = 1'($urandom);
        obj_x = 8'($urandom);
        obj_y = 7'($urandom);
        gap_y = 7'($urandom);
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    task automatic issue(input bit s, input bit e, input int ox, input int oy,
                         input int gy, output int e0);
        @(negedge clk);
        req = 1'b1;
        drive(s, e, ox, oy, gy);
        e0 = edge_n + 1;
        model(s, e, ox, oy, gy, e0);
        @(negedge clk);
        req = 1'b0;
        scramble();
    endtask

    task automatic run(input bit s, input bit e, input int ox, input int oy, input int gy);
        int e0;
        issue(s, e, ox, oy, gy, e0);
        wait_edge(e0 + (s ? 16 : 960) + 3);
    endtask

    always @(negedge clk) begin
        if (!in_reset) begin
            bit exp_busy;
            exp_busy = 1'b0;
            foreach (wlo[i]) if (edge_n >= wlo[i] && edge_n <= whi[i]) exp_busy = 1'b1;
            check("busy", busy, exp_busy);
            if (plot) begin
                if (pq.size() == 0) check("stray_plot", plot, 0);
                else begin
                    pix_t p;
                    p = pq.pop_front();
                    check("pix_cycle", edge_n, p.cyc);
                    check("pix_x", x, p.px);
                    check("pix_y", y, p.py);
                    check("pix_colour", colour, p.c);
                end
            end else if (pq.size() > 0 && pq[0].cyc <= edge_n) begin
                check("plot_missing", plot, 1);
                void'(pq.pop_front());
            end
            if (done) begin
                if (dq.size() == 0) check("stray_done", done, 0);
                else check("done_cycle", edge_n, dq.pop_front());
            end else if (dq.size() > 0 && dq[0] <= edge_n) begin
                check("done_missing", done, 1);
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        int e0, e0b;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_xyc", {x, y, colour}, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;

        run(1, 0, 10, 20, 0);        // bird draw
        run(0, 0, 50, 0, 40);        // wall with gap 40..69
        run(0, 0, 156, 0, 90);       // right-edge clipping
        run(1, 1, 10, 20, 0);        // bird erase
        run(1, 0, 158, 118, 0);      // bird clipped right and bottom
        run(0, 0, 30, 0, 100);       // gap running off the bottom

        // req pulse mid-sweep must be ignored
        issue(1, 0, 40, 60, 0, e0);
        wait_edge(e0 + 8);
        req = 1'b1;
        drive(1, 0, 90, 10, 0);
        @(negedge clk);
        req = 1'b0;
        wait_edge(e0 + 19);

        // req held high: second sweep accepted at E(N+3)
        @(negedge clk);
        req = 1'b1;
        drive(1, 0, 70, 30, 0);
        e0 = edge_n + 1;
        model(1, 0, 70, 30, 0, e0);
        @(negedge clk);
        drive(0, 0, 100, 0, 5);
        e0b = e0 + 19;
        model(0, 0, 100, 0, 5, e0b);
        wait_edge(e0b);
        req = 1'b0;
        scramble();
        wait_edge(e0b + 963);

        // asynchronous reset after 5 plotted pixels
        issue(1, 0, 10, 20, 0, e0);
        wait_edge(e0 + 6);
        #2;
        in_reset = 1'b1;
        resetn   = 1'b0;
        #1;
        check("midrst_plot", plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_xyc", {x, y, colour}, 0);
        pq.delete();
        dq.delete();
        wlo.delete();
        whi.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        run(1, 0, 10, 20, 0);        // fresh sweep after reset

        for (int i = 0; i < 8; i++) begin
            bit s;
            int ox;
            s  = 1'($urandom);
            ox = (i % 2) ? $urandom_range(150, 255) : $urandom_range(0, 159);
            run(s, 1'($urandom), ox, $urandom_range(0, 127), $urandom_range(0, 127));
        end

        repeat (4) @(negedge clk);
        check("pix_queue_empty", pq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flappy_draw_engine.md
Name: flappy_draw_engine

Overview:
- Responder side of the draw-state interface: the control FSM issues a draw request; this block performs it as a per-pixel rectangle sweep into the VGA adapter and returns a done pulse.
- Draws or erases the bird sprite, or one wall column with its fly-through gap.
- Sits between the game control FSM and the vga_adapter's x/y/colour/plot inputs.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
BIRD_W, 4, bird width
BIRD_H, 4, bird height
WALL_W, 8, wall width
GAP_H, 30, wall gap height
BIRD_COLOUR, 3'b110, bird colour
WALL_COLOUR, 3'b010, wall colour
BG_COLOUR, 3'b000, background/erase colour

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous, active-low
req  in  1  draw request, sampled only in IDLE
sel  in  1  object select: 0 = wall, 1 = bird (matches the control FSM encoding DRAW_WALL=0, DRAW_BIRD=1)
erase  in  1  1 = paint the object in BG_COLOUR
obj_x  in  8  object left column
obj_y  in  7  bird top row; ignored for a wall
gap_y  in  7  wall gap top row; ignored for the bird
busy  out  1  request accepted and not yet retired
done  out  1  one-cycle completion pulse
x  out  8  pixel column to the VGA adapter
y  out  7  pixel row to the VGA adapter
colour  out  3  pixel colour
plot  out  1  pixel write enable

Behaviour:
- Reset is asynchronous. While resetn=0, or on its falling edge at any time including mid-sweep: state=IDLE, counters=0, busy=done=plot=0, x=y=colour=0.
- The FSM has four states: IDLE, LOAD, DRAW, DONE.
- IDLE: busy=0. On the edge E0 where req=1:
  - latch sel, erase, obj_x, obj_y, gap_y;
  - clear cx and cy;
  - go to LOAD.
- req is ignored in every state except IDLE. Latched values are unaffected by input changes during the sweep.
- LOAD: one cycle with busy=1 and plot=0. Sets the rectangle:
  - bird: W=BIRD_W, H=BIRD_H, base row = obj_y;
  - wall: W=WALL_W, H=SCREEN_H, base row = 0.
- DRAW: on each edge, the outputs register the pixel for the current (cx, cy), then the counters advance.
  - Pixel position: px = obj_x + cx, computed 9 bits wide; py = base + cy, computed 8 bits wide.
  - Scan order: cx is the inner loop (0..W-1), cy the outer loop (0..H-1).
  - plot=1 unless one of these holds:
    - px >= SCREEN_W;
    - py >= SCREEN_H;
    - the object is a wall and gap_y <= py < gap_y+GAP_H (gap sum computed 8 bits wide).
  - Suppressed pixels still take exactly one cycle, so latency is fixed.
  - x and y carry the low 8 and 7 bits of px and py.
  - colour = BG_COLOUR if erase=1; otherwise BIRD_COLOUR or WALL_COLOUR according to sel.
  - After the pixel at (W-1, H-1), go to DONE.
- Timing: with N=W*H, the pixel outputs are valid in the cycles after edges E2..E(N+1). done=1 and plot=0 in the cycle after edge E(N+2). The FSM returns to IDLE at edge E(N+3).
- busy=1 from edge E0 through the done cycle inclusive.
- Back-to-back requests: if req is held high, the next request is accepted at edge E(N+3).
- x, y and colour hold their last values whenever plot=0.
- Counters are sized to cover SCREEN_H rows and WALL_W columns, so they never wrap during a sweep.

Test Plan:
- Bird draw: req, sel=1, erase=0, obj_x=10, obj_y=20 -> 16 plot pulses, first (10,20), last (13,23), row-major order, colour 110; done exactly once, in the cycle after edge E18; busy high for cycles E0..E18.
- Wall with gap: sel=0, obj_x=50, gap_y=40 -> 960 sweep cycles; plot low for every y in 40..69; all other pixels plotted with x in 50..57 and colour 010.
- Right-edge clipping: wall at obj_x=156 -> plot only for x in 156..159; columns 160..163 suppressed; done still follows edge E962.
- Erase: bird erase at (10,20) -> same 16 coordinates as the bird draw test, colour 000.
- Protocol: req pulsed again mid-sweep with different obj_x -> ignored, coordinates unchanged. req held high continuously -> the second sweep starts at edge E(N+3).
- Reset mid-sweep: drop resetn after 5 pixels -> plot, busy and done go to 0 without waiting for a clock edge. After release, a new req produces a full, fresh sweep starting at (obj_x, obj_y).
